// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM port controller slice.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W = 10;
    localparam int unsigned SRAM_DATA_W = 32;

    // Static macro configuration pins.
    localparam logic [3:0] SRAM_RM_DEFAULT = 4'b0010;
    localparam logic       SRAM_TEST1      = 1'b0;
    localparam logic       SRAM_RME        = 1'b0;

    // Power-management state of one macro port.
    typedef enum logic [1:0] {
        ACTIVE,
        SLEEP,
        WAKE
    } state_t;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry synchronous response FIFO with occupancy output.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    // Qualify push/pop against occupancy; a full FIFO still accepts a push when popping.
    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Single-port initiator for one port of the 1024x32 dual-port SRAM macro:
// request stream to macro pins, registered read data into a 2-entry
// response FIFO, and idle-driven light-sleep management.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = SRAM_ADDR_W,
    parameter int unsigned DATA_W      = SRAM_DATA_W,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] sram_adr,
    output logic [DATA_W-1:0] sram_d,
    output logic [DATA_W-1:0] sram_wem,
    output logic              sram_we,
    output logic              sram_me,
    input  logic [DATA_W-1:0] sram_q,
    output logic              sram_test1,
    output logic              sram_rme,
    output logic [3:0]        sram_rm,
    output logic              sram_ls,
    output logic              sleeping
);

    localparam int unsigned IDLE_W = cnt_width(IDLE_CYCLES);
    localparam int unsigned WAKE_W = cnt_width(WAKE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);
    // A wake period is never shorter than one cycle.
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'((WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic              inflight_q;
    logic [1:0]        fifo_count;
    logic [1:0]        occupancy;
    logic              fire;
    logic              pop;
    logic              idle_now;
    logic              credit_ok;

    // Handshake, credit and idle qualifiers.
    always_comb begin
        fire      = req_valid && req_ready;
        pop       = rsp_valid && rsp_ready;
        occupancy = fifo_count + {1'b0, inflight_q};
        // A same-cycle pop frees a slot, so a sustained read stream with
        // rsp_ready high runs at one read per cycle without overflowing.
        credit_ok = (occupancy < 2'd2) || pop;
        idle_now  = !req_valid && !inflight_q;
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    // Next-state logic: idle timeout into SLEEP, request-triggered timed wake.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ACTIVE: begin
                if (IDLE_CYCLES == 0) begin
                    idle_cnt_d = '0;
                end else if (idle_now) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = SLEEP;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            SLEEP: begin
                if (req_valid) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ACTIVE;
                    idle_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    // State-dependent outputs; requests are only accepted while ACTIVE.
    always_comb begin
        req_ready = (state_q == ACTIVE) && credit_ok;
        sram_ls   = (state_q == SLEEP);
        sleeping  = (state_q == SLEEP);
    end

    // Marks a read whose data the macro presents after the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fire && !req_we;
        end
    end

    sram_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (sram_q),
        .pop_i       (pop),
        .head_o      (rsp_data),
        .count_o     (fifo_count)
    );

    // Macro pin drive.
    always_comb begin
        rsp_valid  = (fifo_count != 2'd0);
        sram_me    = fire;
        sram_we    = fire && req_we;
        sram_adr   = req_addr;
        sram_d     = req_wdata;
        sram_wem   = req_wmask;
        sram_test1 = SRAM_TEST1;
        sram_rme   = SRAM_RME;
        sram_rm    = SRAM_RM_DEFAULT;
    end

endmodule
